layer_mixer: RTL
================

Name: layer_mixer

Overview:
- Parametrised, pipelined successor to the fixed 4-layer priority compositor in the VGA path.
- Selects the highest-index valid and enabled layer per pixel, falling back to a programmable background colour.
- Applies a frame-synchronous global brightness fade for screen transitions.
- Delays hsync/vsync/display-enable to stay aligned with the output pixel.

Parameters:
- NUM_LAYERS, 4, number of input layers; layer NUM_LAYERS-1 has highest priority; valid range 2..8.
- COLOR_W, 8, bits per colour channel; each pixel is 3*COLOR_W bits, ordered {R,G,B}.
- FADE_B, 4, fade resolution; brightness level runs 0..2^FADE_B.

Ports:
- clk  in  1  system pixel clock.
- rst  in  1  reset; synchronous, active-high.
- in_display  in  1  active video area.
- hsync_in  in  1  horizontal sync, aligned with the layer inputs.
- vsync_in  in  1  vertical sync; its rising edge is the frame tick.
- layer_rgb  in  NUM_LAYERS*3*COLOR_W  flattened pixels; layer i occupies bits [i*3*COLOR_W +: 3*COLOR_W].
- layer_valid  in  NUM_LAYERS  per-layer pixel-valid.
- bg_rgb  in  3*COLOR_W  colour used when no layer is valid and enabled.
- mask_wr  in  1  one-cycle strobe: load mask_data as the pending layer-enable mask.
- mask_data  in  NUM_LAYERS  layer-enable bits.
- fade_in  in  1  pulse: start fade to full brightness.
- fade_out  in  1  pulse: start fade to black.
- rgb_out  out  3*COLOR_W  composited, faded pixel.
- hsync_out  out  1  hsync_in delayed by the pipeline latency.
- vsync_out  out  1  vsync_in delayed by the pipeline latency.
- de_out  out  1  in_display delayed by the pipeline latency.
- fade_busy  out  1  high while in FADE_IN or FADE_OUT.
- fade_level  out  FADE_B+1  current brightness level.

Behaviour:
- Reset: rgb_out=0, hsync_out=0, vsync_out=0, de_out=0, all pipeline registers 0, active and pending mask all ones, FSM=FULL, fade_level=2^FADE_B, fade_busy=0.
- Pipeline: fixed 3-cycle latency from inputs to rgb_out/hsync_out/vsync_out/de_out; no stalls.
  - S1: register the winning index and a hit flag. Winner = highest i with layer_valid[i] & mask_active[i]. Register the matching pixel data.
  - S2: register the selected pixel; bg_rgb when there is no hit; 0 when the delayed in_display is 0.
  - S3: per channel, out = (ch * fade_level) >> FADE_B.
    - Product width is COLOR_W+FADE_B+1, truncated to COLOR_W.
    - Level 2^FADE_B gives exact pass-through; level 0 gives black.
- Frame tick: vsync_in high while the registered previous vsync_in is low; one cycle wide.
- Mask:
  - mask_wr loads mask_pending.
  - mask_active <= mask_pending on a frame tick, so there is never a mid-frame change.
  - If mask_wr and the tick occur in the same cycle, mask_data goes straight into mask_active.
- Fade FSM states: BLACK, FADE_IN, FULL, FADE_OUT.
  - fade_in in BLACK or FADE_OUT -> FADE_IN; ignored in FADE_IN or FULL.
  - fade_out in FULL or FADE_IN -> FADE_OUT; ignored in FADE_OUT or BLACK.
  - If fade_in and fade_out arrive in the same cycle, fade_out wins.
  - fade_level changes only on a frame tick: +1 in FADE_IN, -1 in FADE_OUT.
  - FADE_IN reaching 2^FADE_B -> FULL on that tick. FADE_OUT reaching 0 -> BLACK on that tick. No wrap-around.
  - A reversal mid-fade continues from the current level without a jump.
  - A pulse arriving in the same cycle as a tick changes state in that cycle; the step on that tick uses the new state.
- Reset mid-operation (mid-frame or mid-fade) returns every register to its reset value on the next edge.

Optional Feature:
- Macro: LAYER_MIXER_HALF_ALPHA_EN.
- Defined:
  - Adds input layer_half [NUM_LAYERS].
  - If the winning layer w has layer_half[w]=1, the output is the per-channel average (top+under)>>1, truncated.
  - "under" is the next-highest valid and enabled layer below w, or bg_rgb if there is none.
  - Computed within S1/S2; latency stays 3 cycles.
- Undefined: the port is absent and selection is pure priority.

Test Plan:
- Priority: COLOR_W=8, valid=4'b0110, layer1=0x112233, layer2=0xAABBCC, in_display=1 -> rgb_out=0xAABBCC exactly 3 cycles later; de_out and hsync_out aligned to it.
- No hit, then blanking: valid=0, bg_rgb=0x102030 -> rgb_out=0x102030; with in_display=0 -> rgb_out=0.
- Mask deferral: mid-frame mask_wr with mask_data=4'b1011 and layer2 winning -> output unchanged until the next vsync rising edge, then the next lower enabled layer (or bg) wins.
- Fade out: FADE_B=4, fade_out pulse -> fade_busy=1, level 16→15→…→0 over 16 frame ticks, state BLACK, rgb_out=0. At level 8, input 0xFF -> output 0x7F.
- Reversal and reset: fade_in at level 5 during FADE_OUT -> level rises from 5. Simultaneous fade_in/fade_out in BLACK -> stays BLACK. Assert rst mid-fade -> level=16, FULL, outputs 0 on the next edge.
- Half alpha (macro defined): layer3=0xFF0000 with half=1 over layer0=0x0000FF -> rgb_out=0x7F007F.

Source files
------------

// File: rtl/layer_mixer.sv
// Layer compositor: per-pixel priority select, background fill, frame-synchronous fade, 3-cycle aligned syncs.
// Optional LAYER_MIXER_HALF_ALPHA_EN adds layer_half: a flagged winner is averaged with the layer beneath it.
module layer_mixer #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 8,
    parameter int FADE_B     = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_display,
    input  logic                              hsync_in,
    input  logic                              vsync_in,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0]   layer_rgb,
    input  logic [NUM_LAYERS-1:0]             layer_valid,
    input  logic [3*COLOR_W-1:0]              bg_rgb,
    input  logic                              mask_wr,
    input  logic [NUM_LAYERS-1:0]             mask_data,
    input  logic                              fade_in,
    input  logic                              fade_out,
`ifdef LAYER_MIXER_HALF_ALPHA_EN
    input  logic [NUM_LAYERS-1:0]             layer_half,
`endif
    output logic [3*COLOR_W-1:0]              rgb_out,
    output logic                              hsync_out,
    output logic                              vsync_out,
    output logic                              de_out,
    output logic                              fade_busy,
    output logic [FADE_B:0]                   fade_level,
    output logic [1:0]                        fade_state
);
    localparam int PW = 3 * COLOR_W;
    localparam int IW = $clog2(NUM_LAYERS);
    localparam logic [FADE_B:0] LMAX = {1'b1, {FADE_B{1'b0}}};
    localparam logic [FADE_B:0] LONE = {{FADE_B{1'b0}}, 1'b1};

    typedef enum logic [1:0] {BLACK = 2'd0, FADE_IN = 2'd1, FULL = 2'd2, FADE_OUT = 2'd3} fade_state_t;

    fade_state_t state, state_next, state_pulsed;
    logic [FADE_B:0] level_next;
    logic vsync_prev, frame_tick;
    logic [NUM_LAYERS-1:0] mask_pending, mask_active;

    assign frame_tick = vsync_in & ~vsync_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_prev   <= 1'b0;
            mask_pending <= '1;
            mask_active  <= '1;
        end else begin
            vsync_prev <= vsync_in;
            if (mask_wr) mask_pending <= mask_data;
            // A write coinciding with the tick bypasses the pending register.
            if (frame_tick) mask_active <= mask_wr ? mask_data : mask_pending;
        end
    end

    // Winner selection: ascending scan so the highest enabled index wins.
    logic hit;
    logic [IW-1:0] win;
    logic [PW-1:0] top_rgb;
    always_comb begin
        hit = 1'b0;
        win = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (layer_valid[i] & mask_active[i]) begin
                hit = 1'b1;
                win = IW'(i);
            end
        end
        top_rgb = layer_rgb[int'(win)*PW +: PW];
    end

    logic s1_hit, s1_de, s1_hs, s1_vs;
    logic [PW-1:0] s1_rgb, s1_bg;
`ifdef LAYER_MIXER_HALF_ALPHA_EN
    logic [PW-1:0] under_rgb, s1_under;
    logic s1_half;
    always_comb begin
        under_rgb = bg_rgb;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (hit && (i < int'(win)) && layer_valid[i] && mask_active[i])
                under_rgb = layer_rgb[i*PW +: PW];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_under <= '0;
            s1_half  <= 1'b0;
        end else begin
            s1_under <= under_rgb;
            s1_half  <= hit & layer_half[win];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hit <= 1'b0;
            s1_rgb <= '0;
            s1_bg  <= '0;
            s1_de  <= 1'b0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
        end else begin
            s1_hit <= hit;
            s1_rgb <= top_rgb;
            s1_bg  <= bg_rgb;
            s1_de  <= in_display;
            s1_hs  <= hsync_in;
            s1_vs  <= vsync_in;
        end
    end

    logic [PW-1:0] s2_next, s2_rgb;
    logic s2_de, s2_hs, s2_vs;
    always_comb begin
        s2_next = '0;
        if (s1_de) begin
            s2_next = s1_hit ? s1_rgb : s1_bg;
`ifdef LAYER_MIXER_HALF_ALPHA_EN
            if (s1_half) begin
                for (int c = 0; c < 3; c++) begin
                    logic [COLOR_W:0] sum;
                    sum = {1'b0, s1_rgb[c*COLOR_W +: COLOR_W]} + {1'b0, s1_under[c*COLOR_W +: COLOR_W]};
                    s2_next[c*COLOR_W +: COLOR_W] = sum[COLOR_W:1];
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_rgb <= '0;
            s2_de  <= 1'b0;
            s2_hs  <= 1'b0;
            s2_vs  <= 1'b0;
        end else begin
            s2_rgb <= s2_next;
            s2_de  <= s1_de;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
        end
    end

    // Fade: level 2^FADE_B multiplies then shifts back out, giving exact pass-through.
    logic [PW-1:0] s3_next;
    always_comb begin
        logic [COLOR_W+FADE_B:0] prod;
        s3_next = '0;
        prod    = '0;
        for (int c = 0; c < 3; c++) begin
            prod = {{(FADE_B+1){1'b0}}, s2_rgb[c*COLOR_W +: COLOR_W]} * {{COLOR_W{1'b0}}, fade_level};
            s3_next[c*COLOR_W +: COLOR_W] = prod[FADE_B +: COLOR_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out   <= '0;
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            rgb_out   <= s3_next;
            de_out    <= s2_de;
            hsync_out <= s2_hs;
            vsync_out <= s2_vs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FULL;
            fade_level <= LMAX;
        end else begin
            state      <= state_next;
            fade_level <= level_next;
        end
    end

    // Pulses resolve first (fade_out dominates); a same-cycle tick steps in the resolved direction.
    always_comb begin
        state_pulsed = state;
        state_next   = state;
        level_next   = fade_level;
        if (fade_out) begin
            if (state == FULL || state == FADE_IN) state_pulsed = FADE_OUT;
        end else if (fade_in) begin
            if (state == BLACK || state == FADE_OUT) state_pulsed = FADE_IN;
        end
        state_next = state_pulsed;
        if (frame_tick) begin
            case (state_pulsed)
                FADE_IN: begin
                    if (fade_level != LMAX) level_next = fade_level + LONE;
                    if (fade_level >= LMAX - LONE) state_next = FULL;
                end
                FADE_OUT: begin
                    if (fade_level != '0) level_next = fade_level - LONE;
                    if (fade_level <= LONE) state_next = BLACK;
                end
                default: ;
            endcase
        end
    end

    assign fade_busy  = (state == FADE_IN) || (state == FADE_OUT);
    assign fade_state = state;
endmodule
